// File: rtl/mem_port_responder.sv
// Memory-side responder: arbitrates fetch/read/write requests onto one synchronous single-port memory.
// Define MEM_RESP_RR_ARB_EN for round-robin arbitration (default: fixed priority wr > rd > rom).
module mem_port_responder #(
  parameter int DATA_W = 14,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rom_rd,
  input  logic [ADDR_W-1:0] rom_addr,
  input  logic              ram_rd,
  input  logic              ram_wr,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_wdata,
  output logic              rom_garant,
  output logic              ram_garant_rd,
  output logic              ram_garant_wr,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic [1:0] {SRC_WR = 2'd0, SRC_RD = 2'd1, SRC_ROM = 2'd2} src_t;

  state_t            state, state_nxt;
  src_t              src_q, win_src;
  logic              any_req;
  logic [DATA_W-1:0] rdata_q;
  logic [2:0]        req_vec;

  assign req_vec = {rom_rd, ram_rd, ram_wr};
  assign any_req = |req_vec;

`ifdef MEM_RESP_RR_ARB_EN
  src_t last_q;

  function automatic src_t next_src(input src_t s);
    return (s == SRC_ROM) ? SRC_WR : src_t'(s + 2'd1);
  endfunction

  // Search starts at the source after the last one served.
  always_comb begin
    src_t cand;
    logic found;
    win_src = SRC_WR;
    found   = 1'b0;
    cand    = next_src(last_q);
    for (int i = 0; i < 3; i++) begin
      if (!found && req_vec[cand]) begin
        win_src = cand;
        found   = 1'b1;
      end
      cand = next_src(cand);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= SRC_ROM;
    end else if (state == RESP) begin
      last_q <= src_q;
    end
  end
`else
  always_comb begin
    if (ram_wr)      win_src = SRC_WR;
    else if (ram_rd) win_src = SRC_RD;
    else             win_src = SRC_ROM;
  end
`endif

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      src_q         <= SRC_WR;
      busy          <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_re        <= 1'b0;
      mem_we        <= 1'b0;
      rom_garant    <= 1'b0;
      ram_garant_rd <= 1'b0;
      ram_garant_wr <= 1'b0;
      rdata_valid   <= 1'b0;
      rdata_q       <= '0;
    end else begin
      state         <= state_nxt;
      busy          <= (state_nxt != IDLE);
      mem_re        <= 1'b0;
      mem_we        <= 1'b0;
      rom_garant    <= 1'b0;
      ram_garant_rd <= 1'b0;
      ram_garant_wr <= 1'b0;
      rdata_valid   <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            src_q    <= win_src;
            mem_addr <= (win_src == SRC_ROM) ? rom_addr : ram_addr;
            if (win_src == SRC_WR) begin
              mem_wdata <= ram_wdata;
              mem_we    <= 1'b1;
            end else begin
              mem_re    <= 1'b1;
            end
          end
        end
        ACCESS: begin
          rom_garant    <= (src_q == SRC_ROM);
          ram_garant_rd <= (src_q == SRC_RD);
          ram_garant_wr <= (src_q == SRC_WR);
          rdata_valid   <= (src_q != SRC_WR);
        end
        RESP: begin
          if (src_q != SRC_WR) rdata_q <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  // The memory word arrives in the response cycle itself, so it is forwarded
  // while rdata_valid is high and held from the register afterwards.
  assign rdata = rdata_valid ? mem_rdata : rdata_q;

endmodule
